// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Serialized word-organised memory responder with fixed wait states,
// byte/half/word little-endian access and alignment/range error checks.
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             acc_err;
    logic [31:0]      word;
    logic [31:0]      shifted;
    logic [31:0]      load_val;
    logic [3:0]       be;
    logic [31:0]      wsh;
    logic [31:0]      word_d;
    logic             mem_we;

    assign off      = addr_q[1:0];
    assign idx      = addr_q[IDX_W+1:2];
    assign in_range = {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);
    assign acc_err  = (size_q == 2'b11)
                    || (size_q == 2'b01 && off[0])
                    || (size_q == 2'b10 && off != 2'b00)
                    || !in_range;
    assign word     = in_range ? mem_q[idx] : '0;
    assign shifted  = word >> {off, 3'b000};
    assign wsh      = wdata_q << {off, 3'b000};

    always_comb begin
        load_val = shifted;
        be       = 4'b1111;
        case (size_q)
            2'b00: begin
                load_val = {24'h0, shifted[7:0]};
                be       = 4'b0001 << off;
            end
            2'b01: begin
                load_val = {16'h0, shifted[15:0]};
                be       = 4'b0011 << off;
            end
            default: ;
        endcase
        word_d = word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) word_d[8*k +: 8] = wsh[8*k +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Commit happens here, so a reset in WAIT drops the store
                    mem_we  = wr_q && !acc_err;
                    err_d   = acc_err;
                    rdata_d = (acc_err || wr_q) ? 32'h0 : load_val;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx] <= word_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder against a byte-array model;
// a second instance with WAIT_CYCLES = 0 shares the stimulus via a select.
module tb_mem_responder;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;

    logic        req_ready_m;
    logic        resp_valid_m;
    logic [31:0] resp_rdata_m;
    logic        resp_err_m;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [7:0]  mem_m [2][DEPTH*4];

    mem_responder_if if_a ();
    mem_responder_if if_b ();

    assign if_a.req_valid  = req_valid & ~sel;
    assign if_a.resp_ready = resp_ready & ~sel;
    assign if_a.req_write  = req_write;
    assign if_a.req_size   = req_size;
    assign if_a.req_addr   = req_addr;
    assign if_a.req_wdata  = req_wdata;
    assign if_b.req_valid  = req_valid & sel;
    assign if_b.resp_ready = resp_ready & sel;
    assign if_b.req_write  = req_write;
    assign if_b.req_size   = req_size;
    assign if_b.req_addr   = req_addr;
    assign if_b.req_wdata  = req_wdata;

    assign req_ready_m  = sel ? if_b.req_ready  : if_a.req_ready;
    assign resp_valid_m = sel ? if_b.resp_valid : if_a.resp_valid;
    assign resp_rdata_m = sel ? if_b.resp_rdata : if_a.resp_rdata;
    assign resp_err_m   = sel ? if_b.resp_err   : if_a.resp_err;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH*4; i++) mem_m[s][i] = 8'h00;
    endtask

    // Reference: byte-addressed array, size in bytes, plain range arithmetic
    task automatic model_access(input int s, input logic w, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd);
        int n;
        logic [31:0] rd;
        logic e;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (sz == 2'd3) || ((a % n) != 0) || ((64'(a) / 4) >= DEPTH);
        rd = 0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (w) mem_m[s][int'(a) + i] = wd[8*i +: 8];
                else rd[8*i +: 8] = mem_m[s][int'(a) + i];
            end
        end
        exp_err = e;
        exp_rdata = rd;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int hold, output logic [31:0] got_rd,
                          output logic got_err);
        int lat;
        @(negedge clk);
        chk("idle_req_ready", req_ready_m, 1);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        model_access(sel ? 1 : 0, w, sz, a, wd);
        @(posedge clk);
        #1;
        lat = 0;
        do begin
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_size  = 2'($urandom);
            req_addr  = $urandom_range(0, 63);
            req_wdata = $urandom;
            @(posedge clk);
            #1;
            lat++;
            chk("busy_req_ready", req_ready_m, 0);
        end while (!resp_valid_m && lat < 40);
        chk("latency", lat, sel ? 1 : 3);
        got_rd = resp_rdata_m;
        got_err = resp_err_m;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", resp_valid_m, 1);
            chk("hold_req_ready", req_ready_m, 0);
            chk("hold_rdata", resp_rdata_m, got_rd);
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("post_hs_valid", resp_valid_m, 0);
        chk("post_hs_ready", req_ready_m, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid_m) begin
            chk("resp_rdata", resp_rdata_m, exp_rdata);
            chk("resp_err", resp_err_m, exp_err);
        end
    end

    logic [31:0] rd;
    logic        er;

    initial begin
        clear_model();
        #1;
        chk("rst_req_ready", req_ready_m, 1);
        chk("rst_resp_valid", resp_valid_m, 0);
        chk("rst_rdata", resp_rdata_m, 0);
        chk("rst_err", resp_err_m, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req(1, 2'd2, 32'h8, 32'hDEADBEEF, 0, rd, er);
        chk("st8_err", er, 0);
        do_req(0, 2'd2, 32'h8, 32'h0, 0, rd, er);
        chk("ld8", rd, 32'hDEADBEEF);
        chk("ld8_err", er, 0);
        do_req(1, 2'd0, 32'h9, 32'h0000005A, 0, rd, er);
        do_req(0, 2'd2, 32'h8, 32'h0, 0, rd, er);
        chk("ld8_after_byte", rd, 32'hDEAD5AEF);
        do_req(0, 2'd1, 32'hA, 32'h0, 0, rd, er);
        chk("ldh_A", rd, 32'h0000DEAD);
        do_req(0, 2'd1, 32'h3, 32'h0, 0, rd, er);
        chk("ldh_3_err", er, 1);
        chk("ldh_3_rd", rd, 0);
        do_req(1, 2'd2, 32'h102, 32'hFFFFFFFF, 0, rd, er);
        chk("stw_102_err", er, 1);
        chk("stw_102_rd", rd, 0);
        do_req(0, 2'd3, 32'h8, 32'h0, 0, rd, er);
        chk("size3_err", er, 1);
        chk("size3_rd", rd, 0);
        do_req(0, 2'd2, 32'h100, 32'h0, 0, rd, er);
        chk("ldw_100_err", er, 1);
        do_req(0, 2'd2, 32'h0, 32'h0, 0, rd, er);
        chk("ldw_0", rd, 0);
        chk("ldw_0_err", er, 0);
        do_req(0, 2'd2, 32'h8, 32'h0, 5, rd, er);
        chk("hold5_rd", rd, 32'hDEAD5AEF);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = $urandom_range(0, DEPTH*4 + 7);
                default: a = $urandom_range(0, 31);
            endcase
            do_req(1'($urandom), 2'($urandom), a, $urandom,
                   $urandom_range(0, 3), rd, er);
        end

        sel = 1'b1;
        do_req(1, 2'd2, 32'h10, 32'hCAFEF00D, 0, rd, er);
        do_req(0, 2'd0, 32'h13, 32'h0, 0, rd, er);
        chk("w0_ldb", rd, 32'h000000CA);
        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom), 2'($urandom), $urandom_range(0, 47),
                   $urandom, $urandom_range(0, 2), rd, er);
        end
        sel = 1'b0;

        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h4;
        req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("abort_valid", resp_valid_m, 0);
        chk("abort_ready", req_ready_m, 1);
        chk("abort_rdata", resp_rdata_m, 0);
        chk("abort_err", resp_err_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("no_resp_after_abort", resp_valid_m, 0);
        end
        do_req(0, 2'd2, 32'h4, 32'h0, 0, rd, er);
        chk("ld4_after_abort", rd, 0);
        do_req(0, 2'd2, 32'h8, 32'h0, 0, rd, er);
        chk("ld8_after_reset", rd, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
